// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the fetch state encoding for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory, redirect/stall and IF/ID signals for the fetch stage.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] instruction_address;
  logic [31:0]       instruction;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              stall;
  logic              if_id_valid;
  logic [31:0]       if_id_instruction;
  logic [31:0]       if_id_pc_plus4;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output instruction_address,
    input  instruction,
    input  redirect_valid,
    input  redirect_pc,
    input  stall,
    output if_id_valid,
    output if_id_instruction,
    output if_id_pc_plus4,
    output halted,
    output fetch_count
  );

  modport slave (
    input  instruction_address,
    output instruction,
    output redirect_valid,
    output redirect_pc,
    output stall,
    input  if_id_valid,
    input  if_id_instruction,
    input  if_id_pc_plus4,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: flush beats load, load beats bubble, otherwise hold.
module instruction_fetch_unit_if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_plus4_in,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4
);

  // Capture, flush to NOP, or drop valid; everything else holds (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      instruction <= NOP_WORD;
      pc_plus4    <= 32'd0;
    end else if (flush) begin
      valid       <= 1'b0;
      instruction <= NOP_WORD;
    end else if (load) begin
      valid       <= 1'b1;
      instruction <= instruction_in;
      pc_plus4    <= pc_plus4_in;
    end else if (bubble) begin
      valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
//
// state | meaning
// IDLE  | first cycle after reset, address settles, nothing latched
// RUN   | fetching one word per non-stalled cycle
// HALT  | halt word seen, PC frozen, bubbles into decode until redirect
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int          CNT_W     = 16
) (
  input logic clk,
  input logic rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam logic [1:0]  IDLE = 2'(ST_IDLE);
  localparam logic [1:0]  RUN  = 2'(ST_RUN);
  localparam logic [1:0]  HALT = 2'(ST_HALT);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;
  logic             redirect;
  logic             load;
  logic             bubble;
  logic             is_halt;
  logic             unused_redirect_bits;

  assign redirect = bus.redirect_valid;
  assign pc_plus4 = pc + PC_INC;
  assign is_halt  = (bus.instruction == HALT_WORD);
  assign load     = (state == RUN) && !redirect && !bus.stall;
  assign bubble   = (state == HALT) && !redirect && !bus.stall;

  // Low byte-offset bits of the redirect target are dropped on purpose.
  assign unused_redirect_bits = &bus.redirect_pc[1:0];

  assign bus.instruction_address = pc[ADDR_W+1:2];
  assign bus.halted              = halted;
  assign bus.fetch_count         = fetch_count;

  // PC, state and halt flag; a redirect overrides stall and halt in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC_ALIGNED;
      halted <= 1'b0;
    end else if (redirect) begin
      state  <= RUN;
      pc     <= {bus.redirect_pc[31:2], 2'b00};
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (!bus.stall) begin
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Retired-fetch counter, saturating so long runs never look like a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (load && (fetch_count != CNT_MAX)) begin
      fetch_count <= fetch_count + CNT_ONE;
    end
  end

  instruction_fetch_unit_if_id_register u_if_id (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (redirect),
    .load           (load),
    .bubble         (bubble),
    .instruction_in (bus.instruction),
    .pc_plus4_in    (pc_plus4),
    .valid          (bus.if_id_valid),
    .instruction    (bus.if_id_instruction),
    .pc_plus4       (bus.if_id_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  logic [31:0] mem [64];
  int passed = 0;
  int total  = 0;

  instruction_fetch_unit_if #(.ADDR_W(6), .CNT_W(16)) bus ();

  instruction_fetch_unit #(
    .ADDR_W(6), .RESET_PC(32'h0), .HALT_WORD(HW), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.instruction = mem[bus.instruction_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] p4, input logic [31:0] addr, input logic [31:0] cnt);
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
    check({tag, ".instr"}, bus.if_id_instruction, ins);
    check({tag, ".pc4"},   bus.if_id_pc_plus4, p4);
    check({tag, ".addr"},  32'(bus.instruction_address), addr);
    check({tag, ".count"}, 32'(bus.fetch_count), cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(23 + i);
    mem[5] = HW;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #23;
    check_if("reset", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    check("reset.halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;

    step(); check_if("idle", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    step(); check_if("f0", 1'b1, 32'd23, 32'd4, 32'd1, 32'd1);
    step(); check_if("f1", 1'b1, 32'd24, 32'd8, 32'd2, 32'd2);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_if("stall", 1'b1, 32'd24, 32'd8, 32'd2, 32'd2);
    end
    bus.stall = 1'b0;
    step(); check_if("f2", 1'b1, 32'd25, 32'd12, 32'd3, 32'd3);

    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0013;
    step(); check_if("redir13", 1'b0, 32'h0, 32'd12, 32'd4, 32'd3);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    step(); check_if("f4", 1'b1, 32'd27, 32'h14, 32'd5, 32'd4);

    step(); check_if("halt_latch", 1'b1, HW, 32'h18, 32'd5, 32'd5);
    check("halt_latch.halted", 32'(bus.halted), 32'd1);
    bus.stall = 1'b1;
    step(); check_if("halt_stall", 1'b1, HW, 32'h18, 32'd5, 32'd5);
    bus.stall = 1'b0;
    step(); check_if("halt_bubble", 1'b0, HW, 32'h18, 32'd5, 32'd5);
    check("halt_bubble.halted", 32'(bus.halted), 32'd1);
    step(); check_if("halt_bubble2", 1'b0, HW, 32'h18, 32'd5, 32'd5);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    step(); check_if("redir0", 1'b0, 32'h0, 32'h18, 32'd0, 32'd5);
    check("redir0.halted", 32'(bus.halted), 32'd0);
    bus.redirect_valid = 1'b0;
    step(); check_if("resume", 1'b1, 32'd23, 32'd4, 32'd1, 32'd6);

    // redirect coinciding with a halt word at the fetch address
    mem[1] = HW;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_00FC;
    step(); check_if("redir_vs_halt", 1'b0, 32'h0, 32'd4, 32'd63, 32'd6);
    check("redir_vs_halt.halted", 32'(bus.halted), 32'd0);
    mem[1] = 32'd24;
    mem[63] = 32'hABCD_0063;
    bus.redirect_valid = 1'b0;
    step(); check_if("wrap63", 1'b1, 32'hABCD_0063, 32'h100, 32'd0, 32'd7);
    step(); check_if("wrap0", 1'b1, 32'd23, 32'h104, 32'd1, 32'd8);

    // saturate the counter (no halt words in memory)
    mem[5] = 32'd28;
    for (int i = 0; i < 65540; i++) step();
    check("sat", 32'(bus.fetch_count), 32'h0000_FFFF);
    step();
    check("sat_hold", 32'(bus.fetch_count), 32'h0000_FFFF);
    check("sat_valid", 32'(bus.if_id_valid), 32'd1);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_if("async_rst", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    check("async_rst.halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); check_if("rst_idle", 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
    step(); check_if("rst_f0", 1'b1, 32'd23, 32'd4, 32'd1, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
